// File: rtl/usb_crc_pkg.sv
// Shared constants, state type and CRC5 step function for the USB token CRC5 generator.
package usb_crc_pkg;

  localparam int unsigned CRC5_W = 5;

  // x^5 + x^2 + 1, with the x^5 term implied by the shift-out
  localparam logic [CRC5_W-1:0] CRC5_POLY = 5'b00101;
  localparam logic [CRC5_W-1:0] CRC5_SEED = 5'b11111;

  // Output bit counter: counts 0..4 across the SEND phase
  localparam int unsigned CRC5_CNT_W = 3;
  localparam logic [CRC5_CNT_W-1:0] CRC5_LAST_BIT = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND,
    DONE
  } crc5_state_t;

  // One serial LFSR step: feedback is the incoming bit XOR the register MSB
  function automatic logic [CRC5_W-1:0] crc5_step(input logic [CRC5_W-1:0] crc,
                                                  input logic              din);
    logic fb;
    fb = din ^ crc[CRC5_W-1];
    return {crc[CRC5_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : '0);
  endfunction

endpackage

// File: rtl/usb_crc5_fsm.sv
// Control FSM for the CRC5 generator: sequences load, calculate, send and the
// downstream handshake, and counts the five serialised CRC bits.
module usb_crc5_fsm
  import usb_crc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic crc5_start_i,
  input  logic crc5_rec_i,
  output logic seed_load_o,
  output logic calc_en_o,
  output logic send_en_o,
  output logic crc5_ready_o,
  output logic crc5_done_o
);

  crc5_state_t cs, ns;
  logic [CRC5_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, counter and Moore outputs
  always_comb begin
    ns           = cs;
    cnt_d        = cnt_q;
    seed_load_o  = 1'b0;
    calc_en_o    = 1'b0;
    send_en_o    = 1'b0;
    crc5_ready_o = 1'b0;
    crc5_done_o  = 1'b0;
    unique case (cs)
      IDLE: begin
        cnt_d = '0;
        // The entry edge only reloads the seed; s_in is not consumed here
        if (crc5_start_i) begin
          ns          = CALC;
          seed_load_o = 1'b1;
        end
      end
      CALC: begin
        cnt_d = '0;
        if (crc5_start_i) begin
          calc_en_o = 1'b1;
        end else begin
          ns = SEND;
        end
      end
      SEND: begin
        crc5_ready_o = 1'b1;
        send_en_o    = 1'b1;
        if (cnt_q == CRC5_LAST_BIT) begin
          cnt_d = '0;
          ns    = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        crc5_done_o = 1'b1;
        cnt_d       = '0;
        // A simultaneous start is left for the next edge out of IDLE
        if (crc5_rec_i) begin
          ns = IDLE;
        end
      end
      default: begin
        ns    = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= IDLE;
      cnt_q <= '0;
    end else begin
      cs    <= ns;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_crc5_gen.sv
// Bit-serial USB token CRC5 generator: shifts token bits in during CALC, then
// drives the complemented remainder out MSB first during SEND.
module usb_crc5_gen
  import usb_crc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic crc5_start,
  input  logic s_in,
  input  logic crc5_rec,
  output logic crc5_out,
  output logic crc5_ready,
  output logic crc5_done
);

  logic [CRC5_W-1:0] crc_q, crc_d;
  logic              seed_load;
  logic              calc_en;
  logic              send_en;

  usb_crc5_fsm fsm_inst (
    .clk          (clk),
    .rst_n        (rst_n),
    .crc5_start_i (crc5_start),
    .crc5_rec_i   (crc5_rec),
    .seed_load_o  (seed_load),
    .calc_en_o    (calc_en),
    .send_en_o    (send_en),
    .crc5_ready_o (crc5_ready),
    .crc5_done_o  (crc5_done)
  );

  // Datapath next value: reload, LFSR step, or shift out filling with ones
  always_comb begin
    crc_d = crc_q;
    if (seed_load) begin
      crc_d = CRC5_SEED;
    end else if (calc_en) begin
      crc_d = crc5_step(crc_q, s_in);
    end else if (send_en) begin
      crc_d = {crc_q[CRC5_W-2:0], 1'b1};
    end
  end

  // CRC shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC5_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Complemented MSB goes out only while the FSM is in SEND
  assign crc5_out = crc5_ready & ~crc_q[CRC5_W-1];

endmodule

// File: tb/tb_usb_crc5_gen.sv
// Self-checking bench for usb_crc5_gen using a polynomial long-division reference.
module tb_usb_crc5_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic crc5_start;
  logic s_in;
  logic crc5_rec;
  logic crc5_out;
  logic crc5_ready;
  logic crc5_done;

  int total = 0;
  int bad   = 0;

  // Serial-in/parallel-out capture register fed from the DUT output
  logic       h_en;
  logic       h_left;
  logic       h_in;
  logic [4:0] h_q;

  assign h_en   = crc5_ready;
  assign h_left = 1'b1;
  assign h_in   = crc5_out;

  always_ff @(posedge clk) begin
    if (h_en) h_q <= h_left ? {h_q[3:0], h_in} : {h_in, h_q[4:1]};
  end

  always #5 clk = ~clk;

  usb_crc5_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .crc5_start (crc5_start),
    .s_in       (s_in),
    .crc5_rec   (crc5_rec),
    .crc5_out   (crc5_out),
    .crc5_ready (crc5_ready),
    .crc5_done  (crc5_done)
  );

  // Reference: msg[n-1] is the first wire bit. The seed is folded into the top
  // five degrees of the augmented message, then divided by x^5+x^2+1.
  function automatic logic [4:0] ref_crc(input int n, input logic [63:0] msg);
    logic [68:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[5+i] = msg[i];
    for (int j = 0; j < 5; j++) d[n+j] = d[n+j] ^ 1'b1;
    for (int deg = n + 4; deg >= 5; deg--) begin
      if (d[deg]) begin
        d[deg]   = d[deg] ^ 1'b1;
        d[deg-3] = d[deg-3] ^ 1'b1;
        d[deg-5] = d[deg-5] ^ 1'b1;
      end
    end
    return ~d[4:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Entry cycle (s_in ignored), then n message bits, then start low
  task automatic send_token(input int n, input logic [63:0] msg);
    @(negedge clk);
    check("idle_outs", {29'd0, crc5_ready, crc5_done, crc5_out}, 32'd0);
    crc5_start = 1'b1;
    crc5_rec   = 1'b0;
    s_in       = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      s_in = msg[i];
    end
    @(negedge clk);
    crc5_start = 1'b0;
    s_in       = 1'($urandom);
  endtask

  // Gather serial output until done rises, bounded by a cycle budget
  task automatic collect(input bit toggle, output logic [4:0] val, output int nready,
                         output int done_gap);
    int last;
    last     = -1;
    val      = '0;
    nready   = 0;
    done_gap = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (crc5_done) begin
        done_gap = c - last;
        break;
      end
      if (crc5_ready) begin
        val = {val[3:0], crc5_out};
        nready++;
        last = c;
      end
      if (toggle) crc5_start = 1'($urandom_range(0, 1));
    end
    crc5_start = 1'b0;
    check("done_seen", {31'd0, crc5_done}, 32'd1);
    check("done_outs", {30'd0, crc5_ready, crc5_out}, 32'd0);
  endtask

  task automatic finish_done();
    @(negedge clk);
    crc5_rec = 1'b1;
    @(negedge clk);
    crc5_rec = 1'b0;
    check("rec_to_idle", {30'd0, crc5_ready, crc5_done}, 32'd0);
  endtask

  task automatic run_check(input string tag, input int n, input logic [63:0] msg,
                           input bit toggle);
    logic [4:0] val;
    int nready, gap;
    send_token(n, msg);
    collect(toggle, val, nready, gap);
    check({tag, "_crc"}, {27'd0, val}, {27'd0, ref_crc(n, msg)});
    check({tag, "_nready"}, nready, 5);
    check({tag, "_done_gap"}, gap, 1);
    finish_done();
  endtask

  initial begin
    logic [4:0] val;
    int nready, gap;
    logic [63:0] m;
    int n;

    rst_n      = 1'b0;
    crc5_start = 1'b0;
    s_in       = 1'b0;
    crc5_rec   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", {31'd0, crc5_out}, 32'd0);
    check("reset_ready", {31'd0, crc5_ready}, 32'd0);
    check("reset_done", {31'd0, crc5_done}, 32'd0);
    rst_n = 1'b1;

    // Known token: complemented remainder 10100 on the wire
    m = 64'b00001000111;
    send_token(11, m);
    collect(1'b0, val, nready, gap);
    check("known_crc", {27'd0, val}, 32'b10100);
    check("known_helper", {27'd0, h_q}, 32'b10100);
    check("known_nready", nready, 5);
    check("known_done_gap", gap, 1);
    finish_done();

    run_check("zero_token", 11, 64'd0, 1'b0);

    for (int k = 0; k < 100; k++) begin
      m = 64'($urandom_range(0, 2047));
      run_check("rand_token", 11, m, 1'b0);
    end

    // Longer messages are covered end to end
    for (int k = 0; k < 4; k++) begin
      n = int'($urandom_range(12, 40));
      m = {$urandom, $urandom};
      run_check("long_msg", n, m, 1'b0);
    end

    // Zero-length message: start high for one cycle only
    send_token(0, 64'd0);
    collect(1'b0, val, nready, gap);
    check("zero_len_crc", {27'd0, val}, 32'd0);
    check("zero_len_nready", nready, 5);
    finish_done();

    // Hold DONE without acknowledge, then rec and start together
    m = 64'($urandom_range(0, 2047));
    send_token(11, m);
    collect(1'b0, val, nready, gap);
    check("hold_crc", {27'd0, val}, {27'd0, ref_crc(11, m)});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_done", {29'd0, crc5_done, crc5_ready, crc5_out}, 32'b100);
    end
    @(negedge clk);
    crc5_rec   = 1'b1;
    crc5_start = 1'b1;
    m = 64'($urandom_range(0, 2047));
    run_check("rec_start", 11, m, 1'b0);

    // Reset in the middle of SEND, after two bits
    m = 64'($urandom_range(0, 2047));
    send_token(11, m);
    repeat (2) begin
      @(negedge clk);
      check("pre_reset_ready", {31'd0, crc5_ready}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {29'd0, crc5_ready, crc5_done, crc5_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m = 64'($urandom_range(0, 2047));
    run_check("after_reset", 11, m, 1'b0);

    // start toggling during SEND must not disturb the output
    for (int k = 0; k < 6; k++) begin
      m = 64'($urandom_range(0, 2047));
      run_check("toggle_start", 11, m, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
